// File: rtl/tile_load_sequencer_if.sv
// Address/data write streams from the host plus the registered memory write port
// driven by tile_load_sequencer.
interface tile_load_sequencer_if #(
  parameter int IO_DATA_WIDTH = 16
);
  logic [IO_DATA_WIDTH-1:0] a_input;
  logic                     a_valid;
  logic                     a_ready;
  logic [IO_DATA_WIDTH-1:0] b_input;
  logic                     b_valid;
  logic                     b_ready;
  logic [IO_DATA_WIDTH-1:0] mem_addr;
  logic [IO_DATA_WIDTH-1:0] mem_din;
  logic                     int_mem_we;
  logic                     overlap_cache_we;

  modport master (
    output a_input, a_valid, b_input, b_valid,
    input  a_ready, b_ready, mem_addr, mem_din, int_mem_we, overlap_cache_we
  );

  modport slave (
    input  a_input, a_valid, b_input, b_valid,
    output a_ready, b_ready, mem_addr, mem_din, int_mem_we, overlap_cache_we
  );
endinterface

// File: rtl/tile_load_sequencer.sv
// Sequences the host load of one conv tile: a main phase (input + kernel memory),
// an optional overlap-cache phase, then hands the tile to compute and waits for it.
module tile_load_sequencer #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int INPUT_WORDS   = 16384,
  parameter int KERNEL_WORDS  = 512,
  parameter int OVERLAP_WORDS = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 arst_in,
  input  logic                 start,
  input  logic                 tile_has_overlap,
  tile_load_sequencer_if.slave bus,
  output logic                 data_ready,
  input  logic                 fsm_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] tile_count,
  output logic                 addr_err
);

  localparam logic [CNT_WIDTH-1:0] MAIN_TOTAL   = CNT_WIDTH'(INPUT_WORDS + KERNEL_WORDS);
  localparam logic [CNT_WIDTH-1:0] OVL_TOTAL    = CNT_WIDTH'(OVERLAP_WORDS);
  localparam logic [31:0]          INPUT_LIMIT  = INPUT_WORDS;
  localparam logic [31:0]          KERNEL_LIMIT = KERNEL_WORDS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAIN  = 3'd1,
    S_OVL   = 3'd2,
    S_DRAIN = 3'd3,
    S_READY = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_ovl_en;
  logic                     r_busy;
  logic                     r_data_ready;
  logic                     r_addr_err;
  logic                     r_int_we;
  logic                     r_ovl_we;
  logic [IO_DATA_WIDTH-1:0] r_mem_addr;
  logic [IO_DATA_WIDTH-1:0] r_mem_din;
  logic [CNT_WIDTH-1:0]     r_word_cnt;
  logic [CNT_WIDTH-1:0]     r_tile_cnt;
  logic [CNT_WIDTH-1:0]     w_word_inc;
  logic                     w_accepting;
  logic                     w_beat;
  logic                     w_addr_bad;
  logic                     w_clear_cnt;

  // Bit 15 picks the kernel memory; only the index bits that address each memory are range-checked.
  function automatic logic addr_out_of_range(input logic [IO_DATA_WIDTH-1:0] addr);
    logic bad;
    if (addr[15]) begin
      bad = (32'(addr[8:0]) >= KERNEL_LIMIT);
    end else begin
      bad = (32'(addr[13:0]) >= INPUT_LIMIT);
    end
    return bad;
  endfunction

  assign w_accepting = (r_state == S_MAIN) || (r_state == S_OVL);
  // Each ready depends only on the other stream's valid, so no ready/valid loop forms.
  assign bus.a_ready = w_accepting & bus.b_valid;
  assign bus.b_ready = w_accepting & bus.a_valid;
  assign w_beat      = w_accepting & bus.a_valid & bus.b_valid;
  assign w_word_inc  = r_word_cnt + CNT_WIDTH'(1);
  assign w_addr_bad  = addr_out_of_range(bus.a_input);
  assign w_clear_cnt = (w_next != r_state) && ((w_next == S_MAIN) || (w_next == S_OVL));

  // Next-state decode for the load sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_MAIN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MAIN: begin
        if (w_beat && (w_word_inc == MAIN_TOTAL)) begin
          w_next = r_ovl_en ? S_OVL : S_DRAIN;
        end else begin
          w_next = S_MAIN;
        end
      end
      S_OVL: begin
        if (w_beat && (w_word_inc == OVL_TOTAL)) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_OVL;
        end
      end
      S_DRAIN: begin
        w_next = S_READY;
      end
      S_READY: begin
        if (fsm_done) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_READY;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register plus the status flags decoded from the upcoming state.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != S_IDLE);
      r_data_ready <= (w_next == S_READY);
    end
  end

  // Overlap option is captured with start and held for the whole tile.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_ovl_en <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_ovl_en <= tile_has_overlap;
    end else begin
      r_ovl_en <= r_ovl_en;
    end
  end

  // Per-phase beat counter; the final main beat's increment is overridden when OVL is entered.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_word_cnt <= '0;
    end else if (w_clear_cnt) begin
      r_word_cnt <= '0;
    end else if (w_beat) begin
      r_word_cnt <= w_word_inc;
    end else begin
      r_word_cnt <= r_word_cnt;
    end
  end

  // Completed-tile counter, wraps naturally.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_tile_cnt <= '0;
    end else if ((r_state == S_READY) && fsm_done) begin
      r_tile_cnt <= r_tile_cnt + CNT_WIDTH'(1);
    end else begin
      r_tile_cnt <= r_tile_cnt;
    end
  end

  // Registered memory write port: one-cycle strobe after each beat; bad main addresses write nothing.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_int_we   <= 1'b0;
      r_ovl_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_int_we <= w_beat && (r_state == S_MAIN) && !w_addr_bad;
      r_ovl_we <= w_beat && (r_state == S_OVL);
      if (w_beat) begin
        r_mem_addr <= bus.a_input;
        r_mem_din  <= bus.b_input;
      end else begin
        r_mem_addr <= r_mem_addr;
        r_mem_din  <= r_mem_din;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_addr_err <= 1'b0;
    end else if (w_beat && (r_state == S_MAIN) && w_addr_bad) begin
      r_addr_err <= 1'b1;
    end else begin
      r_addr_err <= r_addr_err;
    end
  end

  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_din          = r_mem_din;
  assign bus.int_mem_we       = r_int_we;
  assign bus.overlap_cache_we = r_ovl_we;
  assign data_ready           = r_data_ready;
  assign busy                 = r_busy;
  assign word_count           = r_word_cnt;
  assign tile_count           = r_tile_cnt;
  assign addr_err             = r_addr_err;

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Scoreboard bench for tile_load_sequencer: a tile-level model predicts accepted beats and
// pushes expected writes; a negedge monitor pops them when the DUT strobes.
module tb_tile_load_sequencer;
  localparam int W  = 16;
  localparam int IW = 4;
  localparam int KW = 2;
  localparam int OW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          arst_in = 1'b1;
  logic          start = 1'b0;
  logic          tile_has_overlap = 1'b0;
  logic          fsm_done = 1'b0;
  logic          data_ready;
  logic          busy;
  logic          addr_err;
  logic [CW-1:0] word_count;
  logic [CW-1:0] tile_count;

  tile_load_sequencer_if #(.IO_DATA_WIDTH(W)) bus ();

  tile_load_sequencer #(
    .IO_DATA_WIDTH(W), .INPUT_WORDS(IW), .KERNEL_WORDS(KW), .OVERLAP_WORDS(OW), .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .arst_in(arst_in), .start(start), .tile_has_overlap(tile_has_overlap),
    .bus(bus.slave), .data_ready(data_ready), .fsm_done(fsm_done), .busy(busy),
    .word_count(word_count), .tile_count(tile_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    bit          ovl;
    logic [15:0] addr;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  // Tile-level model: phase 0 idle, 1 main, 2 overlap, 3 loaded (drain/ready)
  int m_phase = 0;
  bit m_ovl = 0;
  int m_count = 0;
  int m_tiles = 0;
  int m_ready_cyc = 0;
  int m_beats = 0;
  bit m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!arst_in) begin
      chk("strobe_exclusive", {31'b0, bus.int_mem_we & bus.overlap_cache_we}, 32'd0);
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("missing_strobe_cycle", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (bus.int_mem_we || bus.overlap_cache_we) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe_queue", 32'(q.size()), 32'd1);
        end else begin
          mon_e = q.pop_front();
          chk("strobe_cycle", cyc, mon_e.due);
          chk("strobe_kind_ovl", {31'b0, bus.overlap_cache_we}, {31'b0, mon_e.ovl});
          chk("mem_addr", {16'b0, bus.mem_addr}, {16'b0, mon_e.addr});
          chk("mem_din", {16'b0, bus.mem_din}, {16'b0, mon_e.data});
        end
      end
    end
  end

  function automatic logic [15:0] gen_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (m_phase == 1) begin
      if ($urandom_range(0, 1) == 1) begin
        a[15]  = 1'b1;
        a[8:0] = 9'($urandom_range(0, KW - 1));
      end else begin
        a[15]   = 1'b0;
        a[13:0] = 14'($urandom_range(0, IW - 1));
      end
    end
    return a;
  endfunction

  task automatic offer(input bit av, input bit bv, input logic [15:0] a, input logic [15:0] d);
    bit   acc;
    bit   bad;
    exp_t e;
    @(negedge clk);
    bus.a_valid = av;
    bus.b_valid = bv;
    bus.a_input = a;
    bus.b_input = d;
    #1;
    acc = (m_phase == 1) || (m_phase == 2);
    chk("a_ready", {31'b0, bus.a_ready}, {31'b0, acc & bv});
    chk("b_ready", {31'b0, bus.b_ready}, {31'b0, acc & av});
    chk("word_count", {16'b0, word_count}, m_count);
    chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
    chk("data_ready", {31'b0, data_ready}, {31'b0, (m_phase == 3) && (cyc >= m_ready_cyc)});
    chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    chk("tile_count", {16'b0, tile_count}, m_tiles % 65536);
    if (acc && av && bv) begin
      m_beats++;
      m_count++;
      e.addr = a;
      e.data = d;
      e.due  = cyc + 1;
      if (m_phase == 1) begin
        bad = a[15] ? (int'(a[8:0]) >= KW) : (int'(a[13:0]) >= IW);
        e.ovl = 1'b0;
        if (bad) m_err = 1'b1;
        else q.push_back(e);
        if (m_count == IW + KW) begin
          if (m_ovl) begin
            m_phase = 2;
            m_count = 0;
          end else begin
            m_phase = 3;
            m_ready_cyc = cyc + 2;
          end
        end
      end else begin
        e.ovl = 1'b1;
        q.push_back(e);
        if (m_count == OW) begin
          m_phase = 3;
          m_ready_cyc = cyc + 2;
        end
      end
    end
  endtask

  task automatic do_start(input bit ovl);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    start = 1'b1;
    tile_has_overlap = ovl;
    @(posedge clk);
    #1;
    start = 1'b0;
    tile_has_overlap = ~ovl;
    m_phase = 1;
    m_ovl = ovl;
    m_count = 0;
  endtask

  task automatic drive_beats(input int n, input bit rand_valid);
    int target;
    int guard;
    bit av;
    bit bv;
    target = m_beats + n;
    guard = 0;
    while (m_beats < target && (m_phase == 1 || m_phase == 2) && guard < 500) begin
      av = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      bv = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      offer(av, bv, gen_addr(), 16'($urandom));
      guard++;
    end
  endtask

  task automatic wait_ready();
    while (cyc < m_ready_cyc) offer(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic finish_tile(input bit with_start);
    @(negedge clk);
    fsm_done = 1'b1;
    start = with_start;
    @(posedge clk);
    #1;
    fsm_done = 1'b0;
    start = 1'b0;
    m_phase = 0;
    m_tiles++;
    offer(1'b1, 1'b1, 16'h0001, 16'h1234);
  endtask

  task automatic pulse_ignored();
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    start = 1'b1;
    fsm_done = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fsm_done = 1'b0;
  endtask

  initial begin
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_input = '0;
    bus.b_input = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data_ready", {31'b0, data_ready}, 32'd0);
    chk("rst_int_we", {31'b0, bus.int_mem_we}, 32'd0);
    chk("rst_ovl_we", {31'b0, bus.overlap_cache_we}, 32'd0);
    chk("rst_tile_count", {16'b0, tile_count}, 32'd0);
    chk("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    @(negedge clk);
    arst_in = 1'b0;
    offer(1'b1, 1'b1, 16'h0002, 16'h5555);

    // Overlap tile with both valids held high, ignored start/fsm_done mid-load
    do_start(1'b1);
    drive_beats(2, 1'b0);
    pulse_ignored();
    drive_beats(100, 1'b0);
    wait_ready();
    finish_tile(1'b0);

    // Address waits for data: no beat until b_valid rises
    do_start(1'b1);
    offer(1'b1, 1'b0, 16'h0003, 16'hBEEF);
    offer(1'b1, 1'b0, 16'h0003, 16'hBEEF);
    offer(1'b1, 1'b0, 16'h0003, 16'hBEEF);
    offer(1'b0, 1'b1, 16'h0003, 16'hBEEF);
    offer(1'b1, 1'b1, 16'h8001, 16'hCAFE);
    drive_beats(100, 1'b1);
    wait_ready();
    finish_tile(1'b0);

    // No overlap: valids offered in READY are refused; start+fsm_done returns to IDLE only
    do_start(1'b0);
    drive_beats(100, 1'b1);
    wait_ready();
    offer(1'b1, 1'b1, 16'h0000, 16'h0F0F);
    offer(1'b1, 1'b1, 16'h0001, 16'hF0F0);
    finish_tile(1'b1);

    // Out-of-range main address: counted, not written, sticky error
    do_start(1'b0);
    offer(1'b1, 1'b1, 16'h0005, 16'hDEAD);
    offer(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_beats(100, 1'b1);
    wait_ready();
    finish_tile(1'b0);

    // Randomized tiles
    for (int t = 0; t < 6; t++) begin
      do_start(1'($urandom_range(0, 1)));
      drive_beats(100, 1'b1);
      wait_ready();
      finish_tile(1'b0);
    end

    // Asynchronous reset in the middle of a main phase
    do_start(1'b1);
    drive_beats(3, 1'b0);
    @(negedge clk);
    #2;
    arst_in = 1'b1;
    #1;
    chk("arst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("arst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    chk("arst_int_we", {31'b0, bus.int_mem_we}, 32'd0);
    chk("arst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    chk("arst_mem_din", {16'b0, bus.mem_din}, 32'd0);
    chk("arst_word_count", {16'b0, word_count}, 32'd0);
    chk("arst_tile_count", {16'b0, tile_count}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_addr_err", {31'b0, addr_err}, 32'd0);
    chk("arst_queue_empty", 32'(q.size()), 32'd0);
    q.delete();
    m_phase = 0;
    m_count = 0;
    m_tiles = 0;
    m_err = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    arst_in = 1'b0;
    offer(1'b1, 1'b1, 16'h0000, 16'h0000);
    do_start(1'b1);
    drive_beats(100, 1'b1);
    wait_ready();
    finish_tile(1'b0);

    offer(1'b0, 1'b0, 16'h0000, 16'h0000);
    offer(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
